// File: rtl/freq_calc_pkg.sv
// Shared definitions for the frequency calculator.
//  - fc_state_e : controller state encoding (IDLE/MUL/DIV/DONE)
//  - F_BASE_DEF : default reference clock frequency in Hz
//  - prod_w/dvd_w : width of fx_cnt*F_BASE and of the rounded dividend
package freq_calc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } fc_state_e;

    localparam int F_BASE_DEF = 100_000_000;

    // Bits needed to hold cnt * f_base without loss.
    function automatic int prod_w(input int cnt_w, input int f_base);
        return cnt_w + $clog2(f_base + 1);
    endfunction

    // One extra bit so the rounding addend can never overflow the product.
    function automatic int dvd_w(input int cnt_w, input int f_base);
        return prod_w(cnt_w, f_base) + 1;
    endfunction

endpackage

// File: rtl/freq_calc_div.sv
// Unsigned radix-2 restoring divider, one quotient bit per clock.
// Ports:
//  clk_i, rst_ni      clock, asynchronous active-low reset
//  start_i            loads dividend/divisor on this edge and starts N_W steps
//  dividend_i         N_W-bit dividend
//  divisor_i          D_W-bit divisor (must be non-zero)
//  busy_o             high while iterating
//  done_o             high during the cycle whose closing edge computes the
//                     last quotient bit; quotient/remainder are final from the
//                     following cycle and hold until the next start
//  quotient_o         N_W-bit quotient
//  remainder_o        D_W-bit remainder
module div_restoring #(
    parameter int N_W = 60,
    parameter int D_W = 32
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           start_i,
    input  logic [N_W-1:0] dividend_i,
    input  logic [D_W-1:0] divisor_i,
    output logic           busy_o,
    output logic           done_o,
    output logic [N_W-1:0] quotient_o,
    output logic [D_W-1:0] remainder_o
);
    localparam int CW = $clog2(N_W + 1);

    // Dividend bits shift out of the top of acc while quotient bits shift in
    // at the bottom, so after N_W steps acc holds the quotient.
    logic [N_W-1:0] acc_q, acc_d;
    logic [D_W-1:0] dvs_q;
    logic [D_W-1:0] rem_q, rem_d;
    logic [CW-1:0]  cnt_q;
    logic           run_q;
    logic [D_W:0]   rem_sh_s;
    logic           ge_s;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        rem_sh_s = {rem_q, acc_q[N_W-1]};
        ge_s     = (rem_sh_s >= {1'b0, dvs_q});
        if (ge_s) begin
            rem_d = D_W'(rem_sh_s - {1'b0, dvs_q});
        end else begin
            rem_d = rem_sh_s[D_W-1:0];
        end
        acc_d = {acc_q[N_W-2:0], ge_s};
    end

    // Operand load on start, then one step per clock until the count expires.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
            dvs_q <= '0;
            rem_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start_i) begin
            acc_q <= dividend_i;
            dvs_q <= divisor_i;
            rem_q <= '0;
            cnt_q <= CW'(N_W);
            run_q <= 1'b1;
        end else if (run_q) begin
            acc_q <= acc_d;
            rem_q <= rem_d;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                run_q <= 1'b0;
            end
        end
    end

    assign busy_o      = run_q;
    assign done_o      = run_q && (cnt_q == CW'(1));
    assign quotient_o  = acc_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/freq_calc.sv
// Converts an equal-precision gate result into a frequency in Hz:
//   freq_out = fx_cnt * F_BASE / fbase_cnt   (optionally rounded)
// Fixed latency of DVD_W+2 cycles (2 cycles when fbase_cnt == 0).
// Ports:
//  sysclk, reset   clock, asynchronous active-low reset
//  meas_valid      1-cycle strobe: fx_cnt/fbase_cnt hold a new gate result
//  fx_cnt          signal edges counted during the gate
//  fbase_cnt       reference edges counted during the gate
//  busy            1 from the accept edge until freq_valid
//  freq_valid      1-cycle strobe: freq_out and flags updated
//  freq_out        frequency in Hz, held until the next result
//  err_div0        last result had fbase_cnt == 0
//  ovf             last quotient did not fit OUT_W and was saturated
//  overrun         sticky: meas_valid seen while busy; cleared on next accept
module freq_calc
    import freq_calc_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int F_BASE = F_BASE_DEF,
    parameter int OUT_W  = 32,
    parameter int ROUND  = 0
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             meas_valid,
    input  logic [CNT_W-1:0] fx_cnt,
    input  logic [CNT_W-1:0] fbase_cnt,
    output logic             busy,
    output logic             freq_valid,
    output logic [OUT_W-1:0] freq_out,
    output logic             err_div0,
    output logic             ovf,
    output logic             overrun
);
    localparam int               DVD_W    = dvd_w(CNT_W, F_BASE);
    localparam logic [DVD_W-1:0] F_BASE_C = DVD_W'(F_BASE);

    fc_state_e        state_q;
    logic [CNT_W-1:0] fx_q, fbase_q;
    logic             busy_q, valid_q, div0_q, ovf_q, overrun_q;
    logic [OUT_W-1:0] freq_q;

    logic [DVD_W-1:0] round_add_s, dividend_s, quo_s;
    logic [CNT_W-1:0] div_rem_s;
    logic             div_start_s, div_done_s, div_busy_s, sat_s;

    // The product is registered by the divider's operand load in the MUL cycle.
    assign round_add_s = (ROUND != 0) ? DVD_W'(fbase_q >> 1) : {DVD_W{1'b0}};
    assign dividend_s  = DVD_W'(fx_q) * F_BASE_C + round_add_s;
    assign div_start_s = (state_q == ST_MUL) && (fbase_q != {CNT_W{1'b0}});
    assign sat_s       = |quo_s[DVD_W-1:OUT_W];

    div_restoring #(
        .N_W(DVD_W),
        .D_W(CNT_W)
    ) u_div (
        .clk_i      (sysclk),
        .rst_ni     (reset),
        .start_i    (div_start_s),
        .dividend_i (dividend_s),
        .divisor_i  (fbase_q),
        .busy_o     (div_busy_s),
        .done_o     (div_done_s),
        .quotient_o (quo_s),
        .remainder_o(div_rem_s)
    );

    // Controller FSM with registered outputs; any request outside IDLE only
    // raises overrun and never disturbs the calculation in flight.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            fx_q      <= '0;
            fbase_q   <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            freq_q    <= '0;
            div0_q    <= 1'b0;
            ovf_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (meas_valid && (state_q != ST_IDLE)) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (meas_valid) begin
                        fx_q      <= fx_cnt;
                        fbase_q   <= fbase_cnt;
                        busy_q    <= 1'b1;
                        overrun_q <= 1'b0;
                        state_q   <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    state_q <= (fbase_q == {CNT_W{1'b0}}) ? ST_DONE : ST_DIV;
                end
                ST_DIV: begin
                    if (div_done_s) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    valid_q <= 1'b1;
                    state_q <= ST_IDLE;
                    if (fbase_q == {CNT_W{1'b0}}) begin
                        freq_q <= {OUT_W{1'b1}};
                        div0_q <= 1'b1;
                        ovf_q  <= 1'b0;
                    end else if (sat_s) begin
                        freq_q <= {OUT_W{1'b1}};
                        div0_q <= 1'b0;
                        ovf_q  <= 1'b1;
                    end else begin
                        freq_q <= quo_s[OUT_W-1:0];
                        div0_q <= 1'b0;
                        ovf_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign freq_valid = valid_q;
    assign freq_out   = freq_q;
    assign err_div0   = div0_q;
    assign ovf        = ovf_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_freq_calc.sv
module tb_freq_calc;

    logic        clk;
    logic        rst_n;
    logic        mv;
    logic [31:0] fx, fb;
    logic        busy0, fv0, dz0, ov0, or0;
    logic        busy1, fv1, dz1, ov1, or1;
    logic [31:0] fo0, fo1;

    int n_cmp;
    int n_err;

    freq_calc #(.ROUND(0)) dut0 (
        .sysclk(clk), .reset(rst_n), .meas_valid(mv), .fx_cnt(fx), .fbase_cnt(fb),
        .busy(busy0), .freq_valid(fv0), .freq_out(fo0), .err_div0(dz0), .ovf(ov0),
        .overrun(or0)
    );

    freq_calc #(.ROUND(1)) dut1 (
        .sysclk(clk), .reset(rst_n), .meas_valid(mv), .fx_cnt(fx), .fbase_cnt(fb),
        .busy(busy1), .freq_valid(fv1), .freq_out(fo1), .err_div0(dz1), .ovf(ov1),
        .overrun(or1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain 64-bit arithmetic. Returns {err_div0, ovf, freq_out}.
    function automatic logic [33:0] ref_freq(input logic [31:0] f_x, input logic [31:0] f_b,
                                             input bit rnd);
        logic [63:0] num, q;
        if (f_b == 32'd0) return {1'b1, 1'b0, 32'hFFFF_FFFF};
        num = 64'(f_x) * 64'd100_000_000 + (rnd ? 64'(f_b / 32'd2) : 64'd0);
        q   = num / 64'(f_b);
        if (q > 64'h0000_0000_FFFF_FFFF) return {1'b0, 1'b1, 32'hFFFF_FFFF};
        return {1'b0, 1'b0, q[31:0]};
    endfunction

    // Issue one request and wait for freq_valid; lat counts cycles after the
    // accept edge (-1 on timeout). Returns in the freq_valid cycle.
    task automatic send_req(input logic [31:0] f_x, input logic [31:0] f_b, output int lat);
        @(negedge clk);
        fx = f_x; fb = f_b; mv = 1'b1;
        @(negedge clk);
        mv = 1'b0;
        lat = 0;
        while (!fv0 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!fv0) lat = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mv = 1'b0; fx = 32'd0; fb = 32'd0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy0, fv0, dz0, ov0, or0, fo0} !== 37'd0) begin
            n_err++; $display("FAIL reset_dut0: got %h expected 0", {busy0, fv0, dz0, ov0, or0, fo0});
        end
        n_cmp++;
        if ({busy1, fv1, dz1, ov1, or1, fo1} !== 37'd0) begin
            n_err++; $display("FAIL reset_dut1: got %h expected 0", {busy1, fv1, dz1, ov1, or1, fo1});
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({busy0, fv0, busy1, fv1} !== 4'd0) begin
            n_err++; $display("FAIL reset_release: got %b expected 0000", {busy0, fv0, busy1, fv1});
        end
    endtask

    typedef struct {
        logic [31:0] f_x;
        logic [31:0] f_b;
        logic [31:0] f;
        logic        d0;
        logic        ov;
        int          lat;
    } dcase_t;

    task automatic test_directed();
        dcase_t      dc [7];
        int          lat;
        logic [33:0] r1;
        dc[0] = '{32'd1000,        32'd100_000_000, 32'd1000,        1'b0, 1'b0, 62};
        dc[1] = '{32'd3,           32'd7,           32'd42857142,    1'b0, 1'b0, 62};
        dc[2] = '{32'd5,           32'd0,           32'hFFFF_FFFF,   1'b1, 1'b0, 2};
        dc[3] = '{32'hFFFF_FFFF,   32'd1,           32'hFFFF_FFFF,   1'b0, 1'b1, 62};
        dc[4] = '{32'd0,           32'd12345,       32'd0,           1'b0, 1'b0, 62};
        dc[5] = '{32'd42,          32'd1,           32'd4200000000,  1'b0, 1'b0, 62};
        dc[6] = '{32'd43,          32'd1,           32'hFFFF_FFFF,   1'b0, 1'b1, 62};
        for (int i = 0; i < 7; i++) begin
            send_req(dc[i].f_x, dc[i].f_b, lat);
            n_cmp++;
            if (lat !== dc[i].lat) begin
                n_err++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, dc[i].lat);
            end
            n_cmp++;
            if (fo0 !== dc[i].f) begin
                n_err++; $display("FAIL dir%0d_freq: got %0d expected %0d", i, fo0, dc[i].f);
            end
            n_cmp++;
            if ({dz0, ov0, busy0} !== {dc[i].d0, dc[i].ov, 1'b0}) begin
                n_err++; $display("FAIL dir%0d_flags: got %b expected %b", i, {dz0, ov0, busy0},
                                  {dc[i].d0, dc[i].ov, 1'b0});
            end
            r1 = ref_freq(dc[i].f_x, dc[i].f_b, 1'b1);
            n_cmp++;
            if ({fv1, dz1, ov1, fo1} !== {1'b1, r1}) begin
                n_err++; $display("FAIL dir%0d_round: got %h expected %h", i, {fv1, dz1, ov1, fo1},
                                  {1'b1, r1});
            end
            @(negedge clk);
            n_cmp++;
            if (fv0 !== 1'b0) begin
                n_err++; $display("FAIL dir%0d_pulse: got %b expected 0", i, fv0);
            end
        end
        // Named rounding case: 3/7 rounds up to 42857143.
        send_req(32'd3, 32'd7, lat);
        n_cmp++;
        if (fo1 !== 32'd42857143) begin
            n_err++; $display("FAIL round_3_7: got %0d expected 42857143", fo1);
        end
    endtask

    task automatic test_random();
        int          lat;
        logic [31:0] rx, rb;
        logic [33:0] r0, r1;
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0: rx = 32'($urandom_range(0, 1000));
                1: rx = $urandom;
                2: rx = 32'd0;
                default: rx = 32'($urandom_range(0, 50));
            endcase
            if ($urandom_range(0, 7) == 0) begin
                rb = 32'd0;
            end else begin
                case ($urandom_range(0, 2))
                    0: rb = 32'($urandom_range(1, 100));
                    1: rb = 32'($urandom_range(50_000_000, 150_000_000));
                    default: rb = $urandom;
                endcase
            end
            r0 = ref_freq(rx, rb, 1'b0);
            r1 = ref_freq(rx, rb, 1'b1);
            send_req(rx, rb, lat);
            n_cmp++;
            if (lat !== ((rb == 32'd0) ? 2 : 62)) begin
                n_err++; $display("FAIL rnd%0d_latency: got %0d for fx=%h fb=%h", i, lat, rx, rb);
            end
            n_cmp++;
            if ({dz0, ov0, fo0} !== r0) begin
                n_err++; $display("FAIL rnd%0d_trunc: got %h expected %h fx=%h fb=%h", i,
                                  {dz0, ov0, fo0}, r0, rx, rb);
            end
            n_cmp++;
            if ({fv1, dz1, ov1, fo1} !== {1'b1, r1}) begin
                n_err++; $display("FAIL rnd%0d_round: got %h expected %h fx=%h fb=%h", i,
                                  {fv1, dz1, ov1, fo1}, {1'b1, r1}, rx, rb);
            end
        end
    endtask

    task automatic test_back_to_back();
        int          lat;
        logic [33:0] r0, r1;
        r0 = ref_freq(32'd123456, 32'd99_000_000, 1'b0);
        r1 = ref_freq(32'd123456, 32'd99_000_000, 1'b1);
        @(negedge clk);
        fx = 32'd123456; fb = 32'd99_000_000; mv = 1'b1;
        @(negedge clk);
        mv = 1'b0;
        for (int j = 1; j <= 61; j++) begin
            @(negedge clk);
            mv = (j == 10 || j == 61);
            if (j == 10) begin fx = 32'd1; fb = 32'd1; end
            if (j == 61) begin fx = 32'd7; fb = 32'd7; end
            if (j == 11) begin
                n_cmp++;
                if ({or0, busy0, fv0} !== 3'b110) begin
                    n_err++; $display("FAIL overrun_set: got %b expected 110", {or0, busy0, fv0});
                end
            end
        end
        @(negedge clk);  // freq_valid cycle; request in DONE was ignored
        n_cmp++;
        if ({fv0, or0, dz0, ov0, fo0} !== {2'b11, r0}) begin
            n_err++; $display("FAIL overrun_result: got %h expected %h", {fv0, or0, dz0, ov0, fo0},
                              {2'b11, r0});
        end
        n_cmp++;
        if ({fv1, dz1, ov1, fo1} !== {1'b1, r1}) begin
            n_err++; $display("FAIL overrun_result_rnd: got %h expected %h", {fv1, dz1, ov1, fo1},
                              {1'b1, r1});
        end
        fx = 32'd2000; fb = 32'd100_000_000; mv = 1'b1;  // first IDLE cycle
        @(negedge clk);
        mv = 1'b0;
        n_cmp++;
        if ({busy0, or0} !== 2'b10) begin
            n_err++; $display("FAIL b2b_accept: got %b expected 10", {busy0, or0});
        end
        lat = 0;
        while (!fv0 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++;
        if ({fo0, or0} !== {32'd2000, 1'b0} || lat !== 62) begin
            n_err++; $display("FAIL b2b_result: got %0d/%b lat %0d expected 2000/0 lat 62",
                              fo0, or0, lat);
        end
    endtask

    task automatic test_reset_abort();
        int          lat;
        bit          seen;
        logic [33:0] r0;
        @(negedge clk);
        fx = 32'd777777; fb = 32'd55_555_555; mv = 1'b1;
        @(negedge clk);
        mv = 1'b0;
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy0, fv0, dz0, ov0, or0, fo0, busy1, fo1} !== 70'd0) begin
            n_err++; $display("FAIL abort_outputs: got %h expected 0",
                              {busy0, fv0, dz0, ov0, or0, fo0, busy1, fo1});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (fv0 || fv1) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++; $display("FAIL abort_no_valid: got %b expected 0", seen);
        end
        r0 = ref_freq(32'd777777, 32'd55_555_555, 1'b0);
        send_req(32'd777777, 32'd55_555_555, lat);
        n_cmp++;
        if ({dz0, ov0, fo0} !== r0 || lat !== 62) begin
            n_err++; $display("FAIL abort_recover: got %h lat %0d expected %h lat 62",
                              {dz0, ov0, fo0}, lat, r0);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
